uart_rx_word_asm: RTL and testbench
===================================

// Module: uart_rx_word_asm
// PURPOSE
//  Parametrised UART RX word assembler. Pops BYTES consecutive bytes from the UART RX FIFO and packs them into one
//  word, in MSB-first or LSB-first order. Presents the word on a valid/ready handshake and discards stale partial
//  words after an inter-byte timeout. Sits between the UART RX FIFO and game-logic consumers of multi-byte commands.
// PARAMETERS
//  BYTES          2        bytes per word; legal range 1..8; word width is 8*BYTES
//  MSB_FIRST      1        1: first received byte lands in word[8*BYTES-1 -: 8]; 0: first byte lands in word[7:0]
//  TIMEOUT_CYCLES 1000000  idle clk cycles after a byte before a partial word is dropped; 0 disables the timeout
// PORTS
//  clk         in   1        system clock
//  rst_n       in   1        asynchronous reset, active low
//  rx_empty    in   1        RX FIFO empty flag
//  r_data      in   8        RX FIFO head byte; first-word-fall-through, valid while !rx_empty
//  rd_uart     out  1        FIFO pop strobe
//  word_data   out  8*BYTES  assembled word; holds the last completed word
//  word_valid  out  1        word_data is new and not yet consumed
//  word_ready  in   1        consumer accepts word_data
//  frame_drop  out  1        1-cycle pulse: partial word discarded by the timeout
//  chk_err     out  1        1-cycle pulse: checksum mismatch; tied 0 unless UART_RX_CHKSUM_EN
// BEHAVIOUR
//  - Reset (async, rst_n=0): rd_uart=0, word_data=0, word_valid=0, frame_drop=0, chk_err=0.
//    Also clears byte_cnt, the shift register and the timeout counter. Any partial word is lost.
//  - All outputs are registered.
//  - Pop rule: rd_uart_nxt=1 iff !rx_empty && !rd_uart && !stall, so there are never back-to-back pops.
//    r_data is sampled at the same edge at which rd_uart rises.
//  - byte_cnt counts 0..BYTES-1. Each sampled byte is placed into the shift register according to MSB_FIRST.
//  - Completion: when the final byte is sampled at edge E, word_data and word_valid=1 update at E.
//    Latency is therefore 0 cycles from the final pop, and byte_cnt returns to 0.
//  - Handshake:
//    - word_valid stays 1 and word_data stays stable until word_ready=1 is sampled; then word_valid clears.
//    - stall=1 when the next pop would complete a word while word_valid && !word_ready.
//    - Non-final bytes of the next word are still collected during a stall.
//    - word_valid && word_ready at the completing edge: the new word loads and word_valid stays 1 (no bubble).
//  - Timeout:
//    - The counter resets on every sampled byte and runs only while byte_cnt>0 and !stall.
//    - At count==TIMEOUT_CYCLES-1: byte_cnt=0, the partial word is discarded, frame_drop pulses.
//    - word_data and word_valid are unaffected.
//    - A byte sampled in the same cycle as the expiry wins: it is accepted and the counter restarts.
//  - FSM (package enum), two states:
//    - ST_COLLECT: popping bytes.
//    - ST_CHECK: awaiting the checksum byte; exists only with the macro.
//    - Illegal or default state: go to ST_COLLECT with byte_cnt=0.
//  - BYTES=1: every pop completes a word.
// CONFIGURATION
//  UART_RX_CHKSUM_EN defined:
//    - After the BYTES payload bytes, the FSM enters ST_CHECK and pops one more byte.
//    - If that byte equals the XOR of the payload bytes: the word completes as above.
//    - On mismatch: the word is dropped, chk_err pulses, word_valid and word_data are unchanged.
//    - The stall condition applies to the checksum pop, not to the last payload pop.
//  UART_RX_CHKSUM_EN undefined:
//    - ST_CHECK is absent and there is no checksum byte.
//    - chk_err is constant 0.
// STRUCTURE
//  - uart_pkg: typedef enum logic [0:0] {ST_COLLECT, ST_CHECK} uart_rx_asm_state_t; localparam BYTE_W=8.
//  - Sub-module uart_rx_timeout: parameter TIMEOUT_CYCLES; inputs clr and run; output expired (1-cycle pulse).
//    The counter width is $clog2(TIMEOUT_CYCLES+1).
// TESTING
//  1 BYTES=2, MSB_FIRST=1, word_ready=1, FIFO holds 0xAB,0xCD -> two rd_uart pulses; word_data=16'hABCD with a
//    1-cycle word_valid.
//  2 BYTES=4, MSB_FIRST=0, bytes 11,22,33,44 -> word_data=32'h44332211.
//  3 BYTES=2, word_ready=0, FIFO holds 01,02,03,04 -> word 0102 held; 03 popped, 04 not popped.
//    Raise word_ready -> 04 popped at the accept edge; word_data=0304 and word_valid stays 1.
//  4 TIMEOUT_CYCLES=10, one byte 0x55, then idle 10 cycles -> frame_drop pulse; next bytes 66,77 -> word 6677.
//  5 CHKSUM_EN, BYTES=2: bytes 12,34,26 -> word 1234. Then bytes 12,34,00 -> chk_err pulse, no word_valid.
//  6 rst_n low mid-word after 1 byte -> all outputs 0 immediately; after release, bytes A1,B2 -> word A1B2.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART RX word assembler.
//   BYTE_W               : width of one UART byte
//   uart_rx_asm_state_t  : assembler FSM states (ST_CHECK is only reachable when the
//                          UART_RX_CHKSUM_EN macro is defined)
package uart_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [0:0] {
    ST_COLLECT = 1'b0,
    ST_CHECK   = 1'b1
  } uart_rx_asm_state_t;

endpackage

// File: rtl/uart_rx_timeout.sv
// Inter-byte timeout counter for the UART RX word assembler.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : restart the count (a byte was sampled); has priority over expiry
//   run        : count this cycle (partial word pending and not stalled)
//   expired    : 1-cycle pulse when the count reaches TIMEOUT_CYCLES-1 while running
// TIMEOUT_CYCLES = 0 disables expiry entirely.
module uart_rx_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic run,
  output logic expired
);

  localparam bit          Enabled = (TIMEOUT_CYCLES != 0);
  localparam int unsigned CntW    = Enabled ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(Enabled ? TIMEOUT_CYCLES - 1 : 0);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            at_max;

  assign at_max  = (cnt_q == CntMax);
  assign expired = Enabled && run && !clr && at_max;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = at_max ? '0 : cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_word_asm.sv
// UART RX word assembler: pops BYTES bytes from a first-word-fall-through RX FIFO, packs
// them MSB-first or LSB-first into one word and offers it on a valid/ready handshake.
// A partial word is dropped after TIMEOUT_CYCLES idle cycles (0 disables the timeout).
// Optional feature macro: UART_RX_CHKSUM_EN -- a trailing XOR checksum byte follows each
// payload; a mismatch drops the word and pulses chk_err.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   rx_empty    : FIFO empty flag           r_data     : FIFO head byte
//   rd_uart     : FIFO pop strobe (never two cycles in a row)
//   word_data   : last completed word       word_valid : word_data not yet consumed
//   word_ready  : consumer accepts word_data
//   frame_drop  : 1-cycle pulse, partial word dropped by timeout
//   chk_err     : 1-cycle pulse, checksum mismatch (constant 0 without the macro)
module uart_rx_word_asm
  import uart_pkg::*;
#(
  parameter int unsigned BYTES          = 2,
  parameter bit          MSB_FIRST      = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    rx_empty,
  input  logic [BYTE_W-1:0]       r_data,
  output logic                    rd_uart,
  output logic [BYTE_W*BYTES-1:0] word_data,
  output logic                    word_valid,
  input  logic                    word_ready,
  output logic                    frame_drop,
  output logic                    chk_err
);

  localparam int unsigned WordW = BYTE_W * BYTES;
  localparam int unsigned CntW  = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(BYTES - 1);

  uart_rx_asm_state_t state_q, state_d;
  logic [CntW-1:0]    byte_cnt_q, byte_cnt_d;
  logic [WordW-1:0]   shift_q, shift_d;
  logic [WordW-1:0]   word_data_q, word_data_d;
  logic               word_valid_q, word_valid_d;
  logic               rd_uart_q, rd_uart_d;
  logic               frame_drop_q, frame_drop_d;
  logic               chk_err_q, chk_err_d;
`ifdef UART_RX_CHKSUM_EN
  logic [BYTE_W-1:0]  xor_q, xor_d;
`endif

  logic             last_byte;
  logic             completing;
  logic             partial;
  logic             state_ok;
  logic             stall;
  logic             pop_now;
  logic             tmo_run;
  logic             tmo_expired;
  logic [WordW-1:0] asm_word;

  // >= rather than == so a corrupted count still terminates the word.
  assign last_byte = (byte_cnt_q >= LastCnt);

`ifdef UART_RX_CHKSUM_EN
  assign completing = (state_q == ST_CHECK);
  assign partial    = (byte_cnt_q != '0) || (state_q == ST_CHECK);
  assign state_ok   = 1'b1;
`else
  assign completing = (state_q == ST_COLLECT) && last_byte;
  assign partial    = (byte_cnt_q != '0);
  assign state_ok   = (state_q == ST_COLLECT);
`endif

  // Only the pop that would complete a word waits for the consumer.
  assign stall   = completing && word_valid_q && !word_ready;
  // r_data is sampled at the same edge rd_uart rises.
  assign pop_now = !rx_empty && !rd_uart_q && !stall && state_ok;
  assign tmo_run = partial && !stall;

  uart_rx_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (pop_now),
    .run    (tmo_run),
    .expired(tmo_expired)
  );

  // Shift register with the head byte placed in the lane selected by byte_cnt.
  always_comb begin
    asm_word = shift_q;
    for (int unsigned i = 0; i < BYTES; i++) begin
      if (byte_cnt_q == CntW'(i)) begin
        if (MSB_FIRST) begin
          asm_word[WordW-1-BYTE_W*i -: BYTE_W] = r_data;
        end else begin
          asm_word[BYTE_W*i +: BYTE_W] = r_data;
        end
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    shift_d      = shift_q;
    word_data_d  = word_data_q;
    word_valid_d = word_valid_q && !word_ready;
    rd_uart_d    = pop_now;
    frame_drop_d = tmo_expired;
    chk_err_d    = 1'b0;
`ifdef UART_RX_CHKSUM_EN
    xor_d        = xor_q;
`endif
    case (state_q)
      ST_COLLECT: begin
        if (pop_now) begin
          shift_d = asm_word;
`ifdef UART_RX_CHKSUM_EN
          xor_d   = (byte_cnt_q == '0) ? r_data : (xor_q ^ r_data);
`endif
          if (last_byte) begin
            byte_cnt_d = '0;
`ifdef UART_RX_CHKSUM_EN
            state_d = ST_CHECK;
`else
            word_data_d  = asm_word;
            word_valid_d = 1'b1;
`endif
          end else begin
            byte_cnt_d = byte_cnt_q + CntW'(1);
          end
        end else if (tmo_expired) begin
          byte_cnt_d = '0;
        end
      end
`ifdef UART_RX_CHKSUM_EN
      ST_CHECK: begin
        if (pop_now) begin
          state_d = ST_COLLECT;
          if (r_data == xor_q) begin
            word_data_d  = shift_q;
            word_valid_d = 1'b1;
          end else begin
            chk_err_d = 1'b1;
          end
        end else if (tmo_expired) begin
          state_d = ST_COLLECT;
        end
      end
`endif
      default: begin
        state_d    = ST_COLLECT;
        byte_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_COLLECT;
      byte_cnt_q   <= '0;
      shift_q      <= '0;
      word_data_q  <= '0;
      word_valid_q <= 1'b0;
      rd_uart_q    <= 1'b0;
      frame_drop_q <= 1'b0;
      chk_err_q    <= 1'b0;
`ifdef UART_RX_CHKSUM_EN
      xor_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      shift_q      <= shift_d;
      word_data_q  <= word_data_d;
      word_valid_q <= word_valid_d;
      rd_uart_q    <= rd_uart_d;
      frame_drop_q <= frame_drop_d;
      chk_err_q    <= chk_err_d;
`ifdef UART_RX_CHKSUM_EN
      xor_q        <= xor_d;
`endif
    end
  end

  assign rd_uart    = rd_uart_q;
  assign word_data  = word_data_q;
  assign word_valid = word_valid_q;
  assign frame_drop = frame_drop_q;
  assign chk_err    = chk_err_q;

endmodule

// File: tb/tb_uart_rx_word_asm.sv
// Bench for uart_rx_word_asm: instance A (2 bytes, MSB first, timeout 10) and instance B
// (4 bytes, LSB first, timeout disabled). FIFOs are queues updated on the falling edge.
module tb_uart_rx_word_asm;

`ifdef UART_RX_CHKSUM_EN
  localparam int ChkEn = 1;
`else
  localparam int ChkEn = 0;
`endif
  localparam int TmoA = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        rx_empty_a, rd_a, wv_a, wr_a, fd_a, ce_a;
  logic [7:0]  r_data_a;
  logic [15:0] wd_a;
  logic        rx_empty_b, rd_b, wv_b, wr_b, fd_b, ce_b;
  logic [7:0]  r_data_b;
  logic [31:0] wd_b;

  uart_rx_word_asm #(.BYTES(2), .MSB_FIRST(1'b1), .TIMEOUT_CYCLES(TmoA)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .rx_empty(rx_empty_a), .r_data(r_data_a), .rd_uart(rd_a),
    .word_data(wd_a), .word_valid(wv_a), .word_ready(wr_a), .frame_drop(fd_a), .chk_err(ce_a)
  );

  uart_rx_word_asm #(.BYTES(4), .MSB_FIRST(1'b0), .TIMEOUT_CYCLES(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .rx_empty(rx_empty_b), .r_data(r_data_b), .rd_uart(rd_b),
    .word_data(wd_b), .word_valid(wv_b), .word_ready(wr_b), .frame_drop(fd_b), .chk_err(ce_b)
  );

  int n_cmp = 0, n_err = 0;
  int n_pop_a = 0, n_pop_b = 0, n_fd_a = 0, n_fd_b = 0, n_ce_a = 0, n_ce_b = 0;
  logic [7:0]  fa[$], fb[$];
  logic [15:0] exp_q[$];
  bit          rand_mode = 1'b0;
  int          rand_left = 0, n_bad_exp = 0;
  bit          rd_a_prev = 1'b0, wv_prev = 1'b0, acc_prev = 1'b0;
  logic [15:0] wd_prev = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic refresh_a();
    rx_empty_a = (fa.size() == 0);
    r_data_a   = (fa.size() != 0) ? fa[0] : 8'h00;
  endtask

  task automatic refresh_b();
    rx_empty_b = (fb.size() == 0);
    r_data_b   = (fb.size() != 0) ? fb[0] : 8'h00;
  endtask

  task automatic push_a(input logic [7:0] b);
    fa.push_back(b);
    refresh_a();
  endtask

  task automatic push_b(input logic [7:0] b);
    fb.push_back(b);
    refresh_b();
  endtask

  // Payload in arrival order, then the XOR checksum (optionally corrupted).
  task automatic push_frame_a(input logic [15:0] w, input bit bad);
    push_a(w[15:8]);
    push_a(w[7:0]);
    if (ChkEn != 0) push_a(w[15:8] ^ w[7:0] ^ (bad ? 8'h5A : 8'h00));
  endtask

  task automatic wait_valid_a(input string name);
    for (int i = 0; i < 40; i++) begin
      if (wv_a) break;
      @(negedge clk);
    end
    chk({name, " valid seen"}, wv_a, 1);
  endtask

  task automatic wait_valid_b(input string name);
    for (int i = 0; i < 60; i++) begin
      if (wv_b) break;
      @(negedge clk);
    end
    chk({name, " valid seen"}, wv_b, 1);
  endtask

  // FIFO A model, event counters and the random-mode scoreboard.
  always @(negedge clk) begin
    if (rd_a) begin
      chk("A pop while empty", fa.size() == 0, 0);
      chk("A back-to-back pop", rd_a_prev, 0);
      if (fa.size() != 0) void'(fa.pop_front());
      n_pop_a++;
    end
    rd_a_prev = rd_a;
    if (fd_a) n_fd_a++;
    if (ce_a) n_ce_a++;
    if (rand_mode) begin
      if (wv_prev && !acc_prev) chk("A held word stable", {wv_a, wd_a}, {1'b1, wd_prev});
      wr_a = ($urandom_range(1) == 1);
      if (rand_left > 0 && fa.size() < 4 && $urandom_range(3) == 0) begin
        logic [15:0] w;
        bit          bad;
        w   = 16'($urandom);
        bad = (ChkEn != 0) && ($urandom_range(3) == 0);
        push_frame_a(w, bad);
        if (bad) n_bad_exp++;
        else exp_q.push_back(w);
        rand_left--;
      end
      if (wv_a && wr_a) begin
        if (exp_q.size() == 0) chk("A unexpected word", wd_a, 16'hxxxx);
        else chk("A random word", wd_a, exp_q.pop_front());
      end
      wv_prev  = wv_a;
      acc_prev = wv_a && wr_a;
      wd_prev  = wd_a;
    end
    refresh_a();
  end

  always @(negedge clk) begin
    if (rd_b) begin
      chk("B pop while empty", fb.size() == 0, 0);
      if (fb.size() != 0) void'(fb.pop_front());
      n_pop_b++;
    end
    if (fd_b) n_fd_b++;
    if (ce_b) n_ce_b++;
    refresh_b();
  end

  typedef struct packed {
    logic        inst_b;  // 0: instance A, 1: instance B
    logic [31:0] bytes;   // arrival order from bit 31 down; A uses the top two bytes
    logic [31:0] exp;
  } vec_t;

  localparam int NV = 6;
  vec_t vecs[NV];

  task automatic run_vec(input vec_t v, input int idx);
    int p0;
    string nm;
    nm = $sformatf("vec%0d", idx);
    if (!v.inst_b) begin
      p0 = n_pop_a;
      push_a(v.bytes[31:24]);
      push_a(v.bytes[23:16]);
      if (ChkEn != 0) push_a(v.bytes[31:24] ^ v.bytes[23:16]);
      wait_valid_a(nm);
      chk({nm, " word"}, wd_a, v.exp);
      @(negedge clk);
      chk({nm, " valid one cycle"}, wv_a, 0);
      @(negedge clk);
      chk({nm, " pop count"}, n_pop_a - p0, 2 + ChkEn);
    end else begin
      p0 = n_pop_b;
      for (int k = 3; k >= 0; k--) push_b(v.bytes[8*k +: 8]);
      if (ChkEn != 0) push_b(v.bytes[31:24] ^ v.bytes[23:16] ^ v.bytes[15:8] ^ v.bytes[7:0]);
      wait_valid_b(nm);
      chk({nm, " word"}, wd_b, v.exp);
      @(negedge clk);
      chk({nm, " valid one cycle"}, wv_b, 0);
      @(negedge clk);
      chk({nm, " pop count"}, n_pop_b - p0, 4 + ChkEn);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, fd0, ce0, k;
    rst_n = 1'b0;
    wr_a  = 1'b1;
    wr_b  = 1'b1;
    refresh_a();
    refresh_b();
    vecs[0] = '{1'b0, 32'hABCD_0000, 32'h0000_ABCD};
    vecs[1] = '{1'b0, 32'h00FF_0000, 32'h0000_00FF};
    vecs[2] = '{1'b0, 32'h8001_0000, 32'h0000_8001};
    vecs[3] = '{1'b1, 32'h1122_3344, 32'h4433_2211};
    vecs[4] = '{1'b1, 32'hDEAD_BEEF, 32'hEFBE_ADDE};
    vecs[5] = '{1'b0, 32'h5AA5_0000, 32'h0000_5AA5};

    repeat (3) @(negedge clk);
    chk("reset outputs A", {rd_a, wd_a, wv_a, fd_a, ce_a}, 0);
    chk("reset outputs B", {rd_b, wd_b, wv_b, fd_b, ce_b}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

    // Consumer not ready: second word's last pop waits for the accept edge.
    wr_a = 1'b0;
    p0   = n_pop_a;
    fd0  = n_fd_a;
    push_frame_a(16'h0102, 1'b0);
    push_frame_a(16'h0304, 1'b0);
    repeat (30) @(negedge clk);
    chk("stall held word", {wv_a, wd_a}, {1'b1, 16'h0102});
    chk("stall pops", n_pop_a - p0, 3 + 2 * ChkEn);
    chk("stall fifo left", fa.size(), 1);
    chk("stall no drop", n_fd_a - fd0, 0);
    wr_a = 1'b1;
    @(negedge clk);
    chk("accept edge word", {wv_a, wd_a}, {1'b1, 16'h0304});
    @(negedge clk);
    chk("accept edge pops", n_pop_a - p0, 4 + 2 * ChkEn);
    chk("accept edge valid clear", wv_a, 0);

    // Timeout: a lone byte is dropped TmoA cycles after it was sampled.
    fd0 = n_fd_a;
    push_a(8'h55);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rd_a) break;
    end
    chk("timeout byte popped", rd_a, 1);
    k = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      k++;
      if (fd_a) break;
    end
    chk("timeout latency", k, TmoA);
    chk("timeout keeps word", {wv_a, wd_a}, {1'b0, 16'h0304});
    @(negedge clk);
    chk("timeout pulse width", fd_a, 0);
    chk("timeout drop count", n_fd_a - fd0, 1);
    push_frame_a(16'h6677, 1'b0);
    wait_valid_a("after drop");
    chk("after drop word", wd_a, 16'h6677);

    // A byte sampled at the expiry edge wins over the timeout.
    repeat (3) @(negedge clk);
    fd0 = n_fd_a;
    push_a(8'h55);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rd_a) break;
    end
    repeat (TmoA - 1) @(negedge clk);
    push_a(8'h66);
    if (ChkEn != 0) push_a(8'h55 ^ 8'h66);
    wait_valid_a("race");
    chk("race word", wd_a, 16'h5566);
    chk("race no drop", n_fd_a - fd0, 0);

    // Timeout disabled on B: a long gap inside a word is tolerated.
    fd0 = n_fd_b;
    push_b(8'h01);
    repeat (40) @(negedge clk);
    push_b(8'h02);
    push_b(8'h03);
    push_b(8'h04);
    if (ChkEn != 0) push_b(8'h01 ^ 8'h02 ^ 8'h03 ^ 8'h04);
    wait_valid_b("no timeout");
    chk("no timeout word", wd_b, 32'h0403_0201);
    chk("no timeout drop count", n_fd_b - fd0, 0);

`ifdef UART_RX_CHKSUM_EN
    repeat (3) @(negedge clk);
    push_a(8'h12);
    push_a(8'h34);
    push_a(8'h26);
    wait_valid_a("chksum good");
    chk("chksum good word", wd_a, 16'h1234);
    repeat (2) @(negedge clk);
    ce0 = n_ce_a;
    push_a(8'h12);
    push_a(8'h34);
    push_a(8'h00);
    k = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (wv_a) k++;
    end
    chk("chksum bad no valid", k, 0);
    chk("chksum bad err pulse", n_ce_a - ce0, 1);
    chk("chksum bad keeps word", wd_a, 16'h1234);
`endif

    // Reset mid-word discards the partial byte.
    repeat (3) @(negedge clk);
    push_a(8'h99);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rd_a) break;
    end
    rst_n = 1'b0;
    #1;
    chk("mid reset outputs A", {rd_a, wd_a, wv_a, fd_a, ce_a}, 0);
    chk("mid reset outputs B", {rd_b, wd_b, wv_b, fd_b, ce_b}, 0);
    fa.delete();
    refresh_a();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push_frame_a(16'hA1B2, 1'b0);
    wait_valid_a("post reset");
    chk("post reset word", wd_a, 16'hA1B2);
    repeat (3) @(negedge clk);

    // Random frames, random consumer readiness.
    fd0       = n_fd_a;
    ce0       = n_ce_a;
    rand_left = 200;
    rand_mode = 1'b1;
    for (int i = 0; i < 20000; i++) begin
      if (rand_left == 0 && fa.size() == 0 && exp_q.size() == 0) break;
      @(negedge clk);
    end
    rand_mode = 1'b0;
    wr_a      = 1'b1;
    repeat (5) @(negedge clk);
    chk("random frames pushed", rand_left, 0);
    chk("random all words seen", exp_q.size(), 0);
    chk("random no drop", n_fd_a - fd0, 0);
    chk("random chk_err count", n_ce_a - ce0, n_bad_exp);
    chk("B never dropped", n_fd_b, 0);
    chk("B never chk_err", n_ce_b, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
